if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage: owns the architectural PC and issues one outstanding 32-bit fetch at a time to the instruction memory port. It holds each returned instruction until the decode stage accepts it, then presents it with its address. It applies redirects from branch/jump resolution, discarding any stale in-flight or held instruction. It sits directly upstream of id_stage and drives id_stage's `inst` and `inst_addr` inputs.

## Interface
Parameters:
- `RESET_PC`, 64'h0000_0000_8000_0000, PC fetched first after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: branch taken or jump resolved this cycle.
- `redirect_target` in 64 (`REG_BUS`): new PC, equal to `inst_addr + jmp_imm` computed downstream.
- `id_ready` in 1: decode accepts the presented instruction this cycle.
- `if_req_valid` out 1: fetch request valid.
- `if_req_ready` in 1: memory accepts the request.
- `if_req_addr` out 64: fetch address. Memory samples it only on the valid&ready handshake.
- `if_rsp_valid` in 1: read data returned. At most one response per accepted request, at least one cycle after acceptance.
- `if_rsp_data` in 32: instruction word.
- `inst_valid` out 1: `inst`/`inst_addr` are valid.
- `inst` out 32: instruction to id_stage. Forced to `INST_NOP` (32'h0000_0013) when `inst_valid`=0.
- `inst_addr` out 64: PC of `inst`. Holds the last PC when invalid.
- `fetch_misalign` out 1: sticky misaligned-redirect flag. Present only with the configuration macro, otherwise tied 0.

## Operation
- State machine with states REQ, WAIT, HOLD, plus HALT when the macro is enabled. Registers: `pc`, `drop`, `inst_q`, `addr_q`.
- **REQ**
  - Drive `if_req_valid`=1 and `if_req_addr`=`pc`.
  - On handshake: go to WAIT and set `addr_q`=`pc`.
  - On `redirect_valid` without handshake: `pc`←target and stay in REQ.
  - On `redirect_valid` in the same cycle as a handshake: the old address is accepted; go to WAIT with `drop`=1 and `pc`←target.
- **WAIT**
  - `if_req_valid`=0.
  - On `if_rsp_valid` with `drop`=0: `inst_q`←data and go to HOLD.
  - On `if_rsp_valid` with `drop`=1: discard the data, clear `drop`, go to REQ.
  - On `redirect_valid` in WAIT: set `drop`=1 and `pc`←target.
  - On redirect coincident with the response: discard the response and go to REQ with the new `pc`.
- **HOLD**
  - `inst_valid`=1, `inst`=`inst_q`, `inst_addr`=`addr_q`.
  - On `id_ready` without redirect: `pc`←`addr_q`+4 and go to REQ.
  - On `redirect_valid`: drop the held instruction, `pc`←target, go to REQ. Redirect takes priority over `id_ready`.
- PC arithmetic is 64-bit unsigned and wraps modulo 2^64.
- The redirect target is taken verbatim; with the macro disabled, bits [1:0] are forced to 0.

## Timing
- Reset values:
  - State REQ, `pc`=`RESET_PC`, `drop`=0.
  - `if_req_valid`=0 during the reset cycle; it is combinational from state and is 1 in the first cycle after `rst` falls.
  - `inst_valid`=0, `inst`=NOP, `inst_addr`=0, `fetch_misalign`=0.
- `rst` asserted mid-operation: the next edge returns to the reset values. A response to a pre-reset request that arrives after reset is ignored, because REQ ignores `if_rsp_valid`.
- Minimum cycles per instruction is 3 (REQ handshake, response, HOLD accept) with a zero-wait memory.
- The presented instruction is stable while `inst_valid`=1 and `id_ready`=0.
- Outputs are registered or state-decoded; there is no combinational path from `if_rsp_data` to `inst`.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - A redirect with target[1:0]≠0 moves the FSM to HALT, sets `fetch_misalign`=1 and sets `inst_valid`=0.
  - An in-flight response is discarded.
  - Only `rst` leaves HALT.
- `IF_MISALIGN_TRAP_EN` undefined: no HALT state, `fetch_misalign`=0, and target bits [1:0] are zeroed.

## Structure
- Add to `defines.v`:
  - `PC_START`
  - `INST_NOP`
  - the fetch-state encodings `IF_REQ`, `IF_WAIT`, `IF_HOLD`, `IF_HALT` (2-bit).
- Reuse the existing `REG_BUS`.
- One sub-module, `if_pc_gen`: the combinational next-PC mux (hold / +4 / redirect / misalign mask) feeding the `pc` register in if_stage.

## Test plan
- Reset, then zero-wait memory with `id_ready`=1 -> `if_req_addr` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; `inst_valid` high every third cycle with the matching `inst_addr`.
- `id_ready`=0 for 5 cycles in HOLD -> `inst` and `inst_addr` stable and no new request; the cycle after `id_ready`=1, the request goes to `addr_q`+4.
- Redirect to 0x8000_0100 while in WAIT -> the response is dropped, `inst_valid` stays 0, and the next request address is 0x8000_0100.
- Redirect in the same cycle as the REQ handshake -> the old address is accepted, its response is discarded, and the next request is to the target.
- Redirect in the same cycle as HOLD with `id_ready`=1 -> the held instruction is not counted as accepted and the next fetch is the target.
- Macro on, redirect to 0x8000_0102 -> `fetch_misalign`=1, `if_req_valid`=0 persistently until `rst`. Macro off -> the next fetch is 0x8000_0100.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned RegBus = 64;

  localparam logic [RegBus-1:0] PcStart = 64'h0000_0000_8000_0000;
  localparam logic [31:0]       InstNop = 32'h0000_0013;

  // Fetch FSM encodings; IfHalt is only reachable with IF_MISALIGN_TRAP_EN.
  typedef enum logic [1:0] {
    IfReq  = 2'b00,
    IfWait = 2'b01,
    IfHold = 2'b10,
    IfHalt = 2'b11
  } if_state_e;

  // Next-PC mux select.
  typedef enum logic [1:0] {
    PcKeep     = 2'b00,
    PcInc      = 2'b01,
    PcRedirect = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port: one request channel plus a response channel.
interface if_stage_if;
  import if_stage_pkg::*;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [RegBus-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data
  );

endinterface

// File: rtl/if_pc_gen.sv
// Combinational next-PC mux: hold, sequential +4, or redirect target.
// With IF_MISALIGN_TRAP_EN the target is taken verbatim and misalignment is flagged;
// otherwise target bits [1:0] are cleared and the flag is constant 0.
module if_pc_gen
  import if_stage_pkg::*;
(
  input  pc_sel_e           sel_i,
  input  logic [RegBus-1:0] pc_i,
  input  logic [RegBus-1:0] addr_i,
  input  logic [RegBus-1:0] target_i,
  output logic [RegBus-1:0] pc_o,
  output logic              misalign_o
);

  logic [RegBus-1:0] target_eff;

`ifdef IF_MISALIGN_TRAP_EN
  assign target_eff = target_i;
  assign misalign_o = |target_i[1:0];
`else
  assign target_eff = target_i & ~64'd3;
  assign misalign_o = 1'b0;
`endif

  // Select the value loaded into the PC register next cycle.
  always_comb begin
    pc_o = pc_i;
    unique case (sel_i)
      PcKeep:     pc_o = pc_i;
      PcInc:      pc_o = addr_i + 64'd4;
      PcRedirect: pc_o = target_eff;
      default:    pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding fetch, holds the returned word until
// decode accepts it, and squashes stale fetches on redirect.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect halts fetch).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [RegBus-1:0] RESET_PC = PcStart
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [RegBus-1:0] redirect_target,
  input  logic              id_ready,
  if_stage_if.master        imem_io,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [RegBus-1:0] inst_addr,
  output logic              fetch_misalign
);

  if_state_e         state_q, state_d;
  logic [RegBus-1:0] pc_q, pc_d;
  logic [RegBus-1:0] addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic              drop_q, drop_d;
  pc_sel_e           pc_sel;
  logic              tgt_misalign;
  logic              handshake;

  if_pc_gen u_pc_gen (
    .sel_i      (pc_sel),
    .pc_i       (pc_q),
    .addr_i     (addr_q),
    .target_i   (redirect_target),
    .pc_o       (pc_d),
    .misalign_o (tgt_misalign)
  );

  // State-decoded outputs; request is suppressed while reset is asserted.
  always_comb begin
    imem_io.if_req_valid = (state_q == IfReq) && !rst;
    imem_io.if_req_addr  = pc_q;
    inst_valid           = (state_q == IfHold);
    inst                 = inst_valid ? inst_q : InstNop;
    inst_addr            = addr_q;
  end

  assign handshake = imem_io.if_req_valid && imem_io.if_req_ready;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = tgt_misalign;
`endif

  // Next-state logic; redirect wins over decode acceptance and response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    pc_sel  = PcKeep;
`ifdef IF_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      IfReq: begin
        if (redirect_valid) pc_sel = PcRedirect;
        if (handshake) begin
          addr_d  = pc_q;
          state_d = IfWait;
          // Old address already accepted; its data must be thrown away.
          drop_d  = redirect_valid;
        end
      end
      IfWait: begin
        if (redirect_valid) begin
          pc_sel = PcRedirect;
          if (imem_io.if_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = IfReq;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_io.if_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IfReq;
          end else begin
            inst_d  = imem_io.if_rsp_data;
            state_d = IfHold;
          end
        end
      end
      IfHold: begin
        if (redirect_valid) begin
          pc_sel  = PcRedirect;
          state_d = IfReq;
        end else if (id_ready) begin
          pc_sel  = PcInc;
          state_d = IfReq;
        end
      end
      default: begin
`ifdef IF_MISALIGN_TRAP_EN
        state_d = IfHalt;
`else
        state_d = IfReq;
`endif
      end
    endcase
`ifdef IF_MISALIGN_TRAP_EN
    // A misaligned redirect parks the stage until reset; in-flight data is ignored.
    if (state_q != IfHalt && redirect_valid && tgt_misalign) begin
      state_d    = IfHalt;
      misalign_d = 1'b1;
      drop_d     = 1'b0;
      pc_sel     = PcKeep;
    end
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IfReq;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      inst_q  <= InstNop;
      drop_q  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a memory responder, a transaction-level
// fetch-stream model checked every cycle, and directed scenarios with literal expectations.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        fetch_misalign;

  if_stage_if mif ();

  if_stage #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .imem_io         (mif),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_addr       (inst_addr),
    .fetch_misalign  (fetch_misalign)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mem_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction word stored at an address; low byte never matches the NOP.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return {a[25:2], 8'h33};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers each accepted request once, mem_lat cycles after the earliest slot.
  initial begin
    logic [63:0] a;
    int lat;
    mif.if_rsp_valid = 1'b0;
    mif.if_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mif.if_req_valid && mif.if_req_ready) begin
        a = mif.if_req_addr;
        @(posedge clk); #1;
        lat = mem_lat;
        repeat (lat) begin @(posedge clk); #1; end
        mif.if_rsp_valid = 1'b1;
        mif.if_rsp_data  = memf(a);
        @(posedge clk); #1;
        mif.if_rsp_valid = 1'b0;
        mif.if_rsp_data  = '0;
      end
    end
  end

  // Reference model: exp_pc is the address of the next instruction the stage owes
  // decode. Every request and every presented instruction must be for exp_pc.
  logic [63:0] exp_pc = 64'h8000_0000;
  bit halted = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 64'h0000_0000_8000_0000;
      halted = 1'b0;
    end else if (halted) begin
      check("halt_req_valid", {63'd0, mif.if_req_valid}, 64'd0);
      check("halt_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("halt_misalign", {63'd0, fetch_misalign}, 64'd1);
    end else begin
      if (!inst_valid) check("nop_when_invalid", {32'd0, inst}, {32'd0, 32'h0000_0013});
      if (mif.if_req_valid && mif.if_req_ready) check("req_addr", mif.if_req_addr, exp_pc);
      if (inst_valid) begin
        check("inst_addr", inst_addr, exp_pc);
        check("inst_data", {32'd0, inst}, {32'd0, memf(exp_pc)});
      end
      if (redirect_valid) begin
`ifdef IF_MISALIGN_TRAP_EN
        if (redirect_target[1:0] != 2'b00) halted = 1'b1;
        exp_pc = redirect_target;
`else
        exp_pc = redirect_target & ~64'd3;
`endif
      end else if (inst_valid && id_ready) begin
        exp_pc = exp_pc + 64'd4;
      end
    end
  end

  // Wait (bounded) for the next request handshake; report its address and cycle.
  task automatic wait_req(output logic [63:0] a, output int c, output bit saw_iv);
    bit got = 1'b0;
    a = '0;
    c = 0;
    saw_iv = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (inst_valid) saw_iv = 1'b1;
      if (mif.if_req_valid && mif.if_req_ready) begin
        got = 1'b1;
        a = mif.if_req_addr;
        c = cyc;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL wait_req: got timeout expected handshake");
    end
  endtask

  // Advance to the first cycle (sampled #1 after the edge) where the condition holds.
  task automatic wait_cond(input bit want_iv);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (want_iv ? inst_valid : mif.if_req_valid) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_cond: got timeout expected state");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {63'd0, mif.if_req_valid}, 64'd0);
    check({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    check({tag, "_inst_nop"}, {32'd0, inst}, 64'h13);
    check({tag, "_inst_addr"}, inst_addr, 64'd0);
    check({tag, "_misalign"}, {63'd0, fetch_misalign}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int c0, c1, c2;
    bit siv;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b1;
    mif.if_req_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Zero-wait memory, decode always ready: one fetch every 3 cycles.
    wait_req(a, c0, siv); check("seq0", a, 64'h8000_0000);
    wait_req(a, c1, siv); check("seq1", a, 64'h8000_0004);
    wait_req(a, c2, siv); check("seq2", a, 64'h8000_0008);
    check("cpi01", 64'(c1 - c0), 64'd3);
    check("cpi12", 64'(c2 - c1), 64'd3);

    // Decode stalls 5 cycles in HOLD: presented word stable, no new request.
    id_ready = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", {63'd0, inst_valid}, 64'd1);
      check("stall_addr", inst_addr, 64'h8000_0008);
      check("stall_noreq", {63'd0, mif.if_req_valid}, 64'd0);
    end
    c0 = cyc;
    mem_lat = 3;
    id_ready = 1'b1;
    wait_req(a, c1, siv);
    check("after_stall_addr", a, 64'h8000_000C);
    check("after_stall_lat", 64'(c1 - c0), 64'd1);

    // Redirect while waiting on a slow response: response dropped.
    @(posedge clk); #1;
    check("wait_state", {62'd0, mif.if_req_valid, inst_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_lat = 0;
    wait_req(a, c1, siv);
    check("wait_redir_addr", a, 64'h8000_0100);
    check("wait_redir_noinst", {63'd0, siv}, 64'd0);

    // Redirect coincident with the request handshake.
    wait_cond(1'b0);
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_req(a, c1, siv);
    check("req_redir_addr", a, 64'h8000_0200);
    check("req_redir_noinst", {63'd0, siv}, 64'd0);

    // Redirect while memory refuses the request: no handshake, PC simply moves.
    mif.if_req_ready = 1'b0;
    wait_cond(1'b0);
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0500;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    check("stalled_redir_addr", mif.if_req_addr, 64'h8000_0500);
    mif.if_req_ready = 1'b1;
    wait_req(a, c1, siv);
    check("stalled_redir_hs", a, 64'h8000_0500);

    // Redirect in HOLD beats id_ready.
    wait_cond(1'b1);
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0300;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_req(a, c1, siv);
    check("hold_redir_addr", a, 64'h8000_0300);

    // Misaligned redirect target.
    wait_cond(1'b1);
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("trap_misalign", {63'd0, fetch_misalign}, 64'd1);
      check("trap_noreq", {63'd0, mif.if_req_valid}, 64'd0);
    end
    @(posedge clk); #1;
`else
    wait_req(a, c1, siv);
    check("mask_addr", a, 64'h8000_0100);
    wait_cond(1'b1);
`endif

    // Reset mid-operation returns to reset values and restarts at RESET_PC.
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    wait_req(a, c1, siv);
    check("restart_addr", a, 64'h8000_0000);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
